clock_divider_prog: RTL and testbench
=====================================

Name: clock_divider_prog

Overview:
Runtime-programmable successor to the fixed 12 MHz→1 MHz divider used in front of the stopwatch core. It divides `clk` by any integer N ≥ 2 and produces two outputs:
- a registered divided clock, `clk_out`, with a high phase of ceil(N/2) cycles;
- a one-cycle `tick` strobe at each period start, for use as a clock-enable.
Divisor changes are staged and applied only at a period boundary, so `clk_out` never glitches. A synchronous restart aligns the divider to external events such as a button reset.

Parameters:
CNT_WIDTH, 16, width of the counter and the divisor.
DEFAULT_DIV, 12, active divisor after reset; must be ≥ 2 and < 2^CNT_WIDTH.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous, active-low reset.
ena  input  1  count enable; when low the divider freezes.
sync_clr  input  1  synchronous restart of the current period.
div_in  input  CNT_WIDTH  requested divisor N.
div_load  input  1  single-cycle strobe that captures `div_in`.
div_pending  output  1  high while a captured divisor waits for a period boundary.
div_active  output  CNT_WIDTH  divisor currently in use.
count  output  CNT_WIDTH  phase counter, range 0..div_active-1.
clk_out  output  1  divided clock, registered.
tick  output  1  one-cycle strobe at period start, registered.

Behaviour:
- Reset (`rst_n` = 0, asynchronous) sets:
  - `div_active` = DEFAULT_DIV, `count` = DEFAULT_DIV-1;
  - `clk_out` = 0, `tick` = 0;
  - `div_pending` = 0, pending register = 0.
  The first enabled cycle after reset wraps the counter, so period start is exactly one `ena` cycle after reset release.
- Clamp: any value captured from `div_in` is clamped as clamp(x) = (x < 2) ? 2 : x.
- H = div_active - floor(div_active/2), i.e. the high-phase length.
- Advance (`ena` = 1, `sync_clr` = 0):
  - If `count` = `div_active`-1, this is a wrap: `count` ← 0.
  - Otherwise `count` ← `count`+1.
  - `clk_out` ← (next count < H), evaluated with the divisor in force for the next count value.
  - `tick` ← 1 on a wrap, else 0.
- Hold (`ena` = 0, `sync_clr` = 0): `count` and `clk_out` hold; `tick` ← 0. The `div_load` capture still operates.
- `div_load`: pending ← clamp(`div_in`) and `div_pending` ← 1. A second load before apply overwrites the pending value.
- Apply: on a wrap with `div_pending` = 1:
  - `div_active` ← pending, and the new period (count 0) already uses the new N and H.
  - `div_pending` clears, unless `div_load` is asserted in the same cycle. In that case the new `div_in` is captured as pending and applied at the following wrap.
- `sync_clr` = 1 has priority over `ena`:
  - `count` ← `div_active`-1, `clk_out` ← 0, `tick` ← 0.
  - If pending, it is applied immediately: `div_active` ← pending, `count` ← pending-1, `div_pending` ← 0.
  - If `div_load` is asserted in the same cycle, `div_active` ← clamp(`div_in`), `count` ← clamp(`div_in`)-1 and `div_pending` ← 0.
- Reset mid-period: asynchronous; all state returns to reset values immediately, and any pending divisor is discarded.
- Duty cycle:
  - Even N gives exactly 50%.
  - Odd N gives high for (N+1)/2 cycles and low for (N-1)/2 cycles.
  - N = 2 gives `clk_out` toggling every cycle, with `tick` on every second cycle.
- `count` never exceeds `div_active`-1, including across divisor changes, because changes take effect only at count 0 or via `sync_clr`.

Test Plan:
1. Reset, then `ena` = 1 held with the default N = 12 → cycle 1: `count` = 0, `clk_out` = 1, `tick` = 1. `clk_out` is then high 6 cycles / low 6 cycles; `tick` repeats every 12 cycles; measured period is 12 over 5 periods.
2. `div_in` = 5 with `div_load` pulsed at `count` = 3 (N = 12) → `div_pending` = 1 until the next wrap. Then `div_active` = 5 and `clk_out` follows a high 3 / low 2 pattern. No `clk_out` pulse is shorter than min(old, new) phase.
3. `div_load` with `div_in` = 0, then with `div_in` = 1 → each applies as N = 2: `clk_out` alternates 1,0,1,0 and `tick` fires every 2 cycles.
4. `ena` toggled 1,0,0,1 at N = 4 → `count` and `clk_out` frozen for 2 cycles, `tick` = 0 while frozen, and the period stretches to 6 cycles.
5. `sync_clr` at `count` = 7 (N = 12) with `div_load` `div_in` = 8 in the same cycle → `div_active` = 8, `clk_out` = 0. The next enabled cycle gives `tick` = 1 and `count` = 0, followed by a high 4 / low 4 pattern.
6. `rst_n` pulled low mid-period with a divisor pending → all outputs go to reset values asynchronously, `div_pending` = 0 and `div_active` = 12. After release, the behaviour of test 1 repeats.

Source files
------------

// File: rtl/clock_divider_prog.sv
// Programmable integer clock divider: registered divided clock plus a period-start tick.
// Divisor changes are staged and take effect only at a period boundary or on sync_clr.
module clock_divider_prog #(
    parameter int CNT_WIDTH   = 16,
    parameter int DEFAULT_DIV = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 sync_clr,
    input  logic [CNT_WIDTH-1:0] div_in,
    input  logic                 div_load,
    output logic                 div_pending,
    output logic [CNT_WIDTH-1:0] div_active,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 clk_out,
    output logic                 tick
);

    localparam logic [CNT_WIDTH-1:0] DEF_DIV = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] MIN_DIV = CNT_WIDTH'(2);

    logic [CNT_WIDTH-1:0] pend_div;
    logic [CNT_WIDTH-1:0] div_in_c;
    logic [CNT_WIDTH-1:0] high_len;
    logic [CNT_WIDTH-1:0] next_cnt;
    logic                 wrap;

    function automatic logic [CNT_WIDTH-1:0] clamp_div(input logic [CNT_WIDTH-1:0] x);
        return (x < MIN_DIV) ? MIN_DIV : x;
    endfunction

    always_comb begin
        div_in_c = clamp_div(div_in);
        high_len = div_active - (div_active >> 1);
        wrap     = (count == div_active - ONE);
        next_cnt = count + ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_active  <= DEF_DIV;
            count       <= DEF_DIV - ONE;
            clk_out     <= 1'b0;
            tick        <= 1'b0;
            div_pending <= 1'b0;
            pend_div    <= '0;
        end else if (sync_clr) begin
            // Restart parks the counter on the last phase so the next enabled cycle is a wrap.
            clk_out     <= 1'b0;
            tick        <= 1'b0;
            div_pending <= 1'b0;
            if (div_load) begin
                div_active <= div_in_c;
                count      <= div_in_c - ONE;
            end else if (div_pending) begin
                div_active <= pend_div;
                count      <= pend_div - ONE;
            end else begin
                count <= div_active - ONE;
            end
        end else begin
            if (ena) begin
                if (wrap) begin
                    count   <= '0;
                    clk_out <= 1'b1;
                    tick    <= 1'b1;
                    if (div_pending) begin
                        div_active <= pend_div;
                        if (!div_load) begin
                            div_pending <= 1'b0;
                        end
                    end
                end else begin
                    count   <= next_cnt;
                    clk_out <= (next_cnt < high_len);
                    tick    <= 1'b0;
                end
            end else begin
                tick <= 1'b0;
            end
            // A load in the wrap cycle becomes the next staged divisor, the old one applies now.
            if (div_load) begin
                pend_div    <= div_in_c;
                div_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog: period-position model checked every cycle,
// plus hand-written tick/clk_out patterns and register literals.
module tb_clock_divider_prog;

    localparam int W   = 16;
    localparam int DEF = 12;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         ena = 1'b0;
    logic         sync_clr = 1'b0;
    logic [W-1:0] div_in = '0;
    logic         div_load = 1'b0;
    logic         div_pending;
    logic [W-1:0] div_active;
    logic [W-1:0] count;
    logic         clk_out;
    logic         tick;

    clock_divider_prog #(.CNT_WIDTH(W), .DEFAULT_DIV(DEF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .sync_clr   (sync_clr),
        .div_in     (div_in),
        .div_load   (div_load),
        .div_pending(div_pending),
        .div_active (div_active),
        .count      (count),
        .clk_out    (clk_out),
        .tick       (tick)
    );

    // clock / reset
    always #5 clk = ~clk;

    // model: position inside the current period of length m_n
    int m_n      = DEF;
    int m_pos    = DEF - 1;
    int m_pend_n = 0;
    bit m_pend   = 1'b0;
    bit m_tick   = 1'b0;

    function automatic int clampi(input int x);
        return (x < 2) ? 2 : x;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = DEF; m_pos = DEF - 1; m_pend = 1'b0; m_pend_n = 0; m_tick = 1'b0;
        end else if (sync_clr) begin
            m_tick = 1'b0;
            if (div_load) begin
                m_n = clampi(int'(div_in)); m_pend = 1'b0;
            end else if (m_pend) begin
                m_n = m_pend_n; m_pend = 1'b0;
            end
            m_pos = m_n - 1;
        end else begin
            if (ena) begin
                m_pos  = (m_pos + 1) % m_n;
                m_tick = (m_pos == 0);
                if (m_tick && m_pend) begin
                    m_n = m_pend_n; m_pend = 1'b0;
                end
            end else begin
                m_tick = 1'b0;
            end
            if (div_load) begin
                m_pend_n = clampi(int'(div_in)); m_pend = 1'b1;
            end
        end
    end

    // scoreboard: literal {tick, clk_out} patterns and register literals
    typedef struct {
        int idx;
        int val;
    } lit_t;

    logic [1:0] exp_q[$];
    lit_t       lit_q[$];
    event       chk_ev;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    always begin
        logic [1:0] e;
        lit_t       l;
        @(negedge clk or chk_ev);
        chk("count", int'(count), m_pos);
        chk("div_active", int'(div_active), m_n);
        chk("div_pending", int'(div_pending), int'(m_pend));
        chk("tick", int'(tick), int'(m_tick));
        chk("clk_out", int'(clk_out), int'(m_pos < (m_n + 1) / 2));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("lit_tick", int'(tick), int'(e[1]));
            chk("lit_clk_out", int'(clk_out), int'(e[0]));
        end
        while (lit_q.size() > 0) begin
            l = lit_q.pop_front();
            case (l.idx)
                0:       chk("lit_count", int'(count), l.val);
                1:       chk("lit_div_active", int'(div_active), l.val);
                default: chk("lit_div_pending", int'(div_pending), l.val);
            endcase
        end
    end

    // driver tasks
    task automatic push_tc(input bit t, input bit c);
        exp_q.push_back({t, c});
    endtask

    task automatic lit(input int idx, input int v);
        lit_t l;
        l.idx = idx;
        l.val = v;
        lit_q.push_back(l);
    endtask

    task automatic step(input bit e, input bit c, input bit l, input int d);
        ena      = e;
        sync_clr = c;
        div_load = l;
        div_in   = W'(d);
        @(posedge clk);
        @(negedge clk);
        #1;
        div_load = 1'b0;
        sync_clr = 1'b0;
    endtask

    task automatic run_default(input int n);
        for (int i = 0; i < n; i++) begin
            push_tc(i % 12 == 0, i % 12 < 6);
            step(1'b1, 1'b0, 1'b0, 0);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        lit(0, 11); lit(1, 12); lit(2, 0); push_tc(1'b0, 1'b0);
        -> chk_ev;
        #1 rst_n = 1'b1;

        // 1: default N=12, five periods
        run_default(60);

        // 2: load 5 at count 3, applies at next wrap
        repeat (4) step(1'b1, 1'b0, 1'b0, 0);
        lit(0, 4); lit(2, 1);
        step(1'b1, 1'b0, 1'b1, 5);
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin
                lit(1, 12); lit(2, 1); lit(0, 11);
            end
            step(1'b1, 1'b0, 1'b0, 0);
        end
        lit(1, 5); lit(2, 0);
        for (int i = 0; i < 10; i++) begin
            push_tc(i % 5 == 0, i % 5 < 3);
            step(1'b1, 1'b0, 1'b0, 0);
        end

        // 3: divisors 0 and 1 clamp to 2
        for (int k = 0; k < 2; k++) begin
            lit(2, 1);
            step(1'b0, 1'b0, 1'b1, k);
            lit(1, 2); lit(2, 0);
            for (int i = 0; i < 4; i++) begin
                push_tc(i % 2 == 0, i % 2 == 0);
                step(1'b1, 1'b0, 1'b0, 0);
            end
        end

        // 4: N=4 with ena 1,1,0,0,1,1,1 -> period stretched to 6
        step(1'b0, 1'b0, 1'b1, 4);
        lit(1, 4);
        push_tc(1'b1, 1'b1); step(1'b1, 1'b0, 1'b0, 0);
        push_tc(1'b0, 1'b1); step(1'b1, 1'b0, 1'b0, 0);
        lit(0, 1);
        push_tc(1'b0, 1'b1); step(1'b0, 1'b0, 1'b0, 0);
        lit(0, 1);
        push_tc(1'b0, 1'b1); step(1'b0, 1'b0, 1'b0, 0);
        push_tc(1'b0, 1'b0); step(1'b1, 1'b0, 1'b0, 0);
        push_tc(1'b0, 1'b0); step(1'b1, 1'b0, 1'b0, 0);
        push_tc(1'b1, 1'b1); step(1'b1, 1'b0, 1'b0, 0);

        // 5: sync_clr at count 7 of N=12 with load 8 in the same cycle
        step(1'b0, 1'b0, 1'b1, 12);
        repeat (3) step(1'b1, 1'b0, 1'b0, 0);
        lit(1, 12); lit(0, 0);
        step(1'b1, 1'b0, 1'b0, 0);
        repeat (7) step(1'b1, 1'b0, 1'b0, 0);
        lit(1, 8); lit(0, 7); lit(2, 0); push_tc(1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8);
        for (int i = 0; i < 9; i++) begin
            if (i == 0) lit(0, 0);
            push_tc(i % 8 == 0, i % 8 < 4);
            step(1'b1, 1'b0, 1'b0, 0);
        end

        // 6: asynchronous reset mid-period with a divisor pending
        step(1'b0, 1'b0, 1'b1, 5);
        lit(2, 1);
        repeat (3) step(1'b1, 1'b0, 1'b0, 0);
        #1 rst_n = 1'b0;
        #1;
        lit(0, 11); lit(1, 12); lit(2, 0); push_tc(1'b0, 1'b0);
        -> chk_ev;
        #1;
        @(negedge clk);
        #1 rst_n = 1'b1;
        run_default(24);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0 || lit_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size() + lit_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
